regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between NREQ writeback sources (0 = ALU, 1 = load, 2 = LDM/base writeback).

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/wb_starve_ctr.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and writeback source indices for the
// register file write-port arbiter.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 16;

    localparam int WB_SRC_ALU  = 0;
    localparam int WB_SRC_LOAD = 1;
    localparam int WB_SRC_LDM  = 2;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating per-requester starvation counter; at_limit
// promotes the requester to top priority.
module wb_starve_ctr
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback sources onto the single regfile
// write port and tracks in-flight destination registers.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [RF_ADDR_W*NREQ-1:0] req_reg,
    input  logic [RF_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      claim_valid,
    input  logic [RF_ADDR_W-1:0]      claim_reg,
    input  logic                      flush,
    output logic [RF_ADDR_W-1:0]      rf_write,
    output logic                      rf_write_req,
    output logic [RF_DATA_W-1:0]      rf_write_data,
    output logic [RF_NREGS-1:0]       pending
);

    logic [NREQ-1:0]      at_limit;
    logic [NREQ-1:0]      starving;
    logic [NREQ-1:0]      ready;
    logic                 found;
    logic [RF_ADDR_W-1:0] sel_reg;
    logic [RF_DATA_W-1:0] sel_data;

    logic                 wr_req_q;
    logic                 wr_req_d;
    logic [RF_ADDR_W-1:0] wr_addr_q;
    logic [RF_ADDR_W-1:0] wr_addr_d;
    logic [RF_DATA_W-1:0] wr_data_q;
    logic [RF_DATA_W-1:0] wr_data_d;
    logic [RF_NREGS-1:0]  pend_q;
    logic [RF_NREGS-1:0]  pend_d;

    for (genvar g = 0; g < NREQ; g++) begin : g_ctr
        wb_starve_ctr #(
            .LIMIT (STARVE_LIMIT)
        ) u_ctr (
            .clk      (clk),
            .rst_b    (rst_b),
            .clr      (ready[g] | ~req_valid[g] | flush),
            .inc      (req_valid[g] & ~ready[g]),
            .at_limit (at_limit[g])
        );
    end

    // Starved requesters first, then plain lowest-index.
    always_comb begin
        ready    = '0;
        found    = 1'b0;
        starving = req_valid & at_limit;
        for (int i = 0; i < NREQ; i++) begin
            if (starving[i] && !found) begin
                ready[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !found) begin
                ready[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (flush || !rst_b) begin
            ready = '0;
        end
    end

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                sel_reg  = sel_reg
                         | req_reg[RF_ADDR_W*i +: RF_ADDR_W];
                sel_data = sel_data
                         | req_data[RF_DATA_W*i +: RF_DATA_W];
            end
        end
    end

    always_comb begin
        wr_req_d  = |ready;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (|ready) begin
            wr_addr_d = sel_reg;
            wr_data_d = sel_data;
        end
    end

    // A fresh claim outlives the write retiring this cycle.
    always_comb begin
        pend_d = pend_q;
        if (wr_req_q) begin
            pend_d[wr_addr_q] = 1'b0;
        end
        if (claim_valid) begin
            pend_d[claim_reg] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pend_q    <= '0;
        end else begin
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pend_q    <= pend_d;
        end
    end

    assign req_ready     = ready;
    assign rf_write      = wr_addr_q;
    assign rf_write_req  = wr_req_q;
    assign rf_write_data = wr_data_q;
    assign pending       = pend_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue of
// expected regfile writes checked on every cycle.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } wr_t;

    logic             clk;
    logic             rst_b;
    logic [NREQ-1:0]  req_valid;
    logic [4*NREQ-1:0]  req_reg;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             claim_valid;
    logic [3:0]       claim_reg;
    logic             flush;
    logic [3:0]       rf_write;
    logic             rf_write_req;
    logic [31:0]      rf_write_data;
    logic [15:0]      pending;

    wr_t exp_q[$];
    int  n_asrt;
    int  n_fail;

    regfile_wb_arbiter #(
        .NREQ         (NREQ),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .req_valid     (req_valid),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .claim_valid   (claim_valid),
        .claim_reg     (claim_reg),
        .flush         (flush),
        .rf_write      (rf_write),
        .rf_write_req  (rf_write_req),
        .rf_write_data (rf_write_data),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] r,
                        input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Advance one cycle and score any write now visible.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (rf_write_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(rf_write_req), 0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(rf_write), 32'(w.r));
                chk("wr_data", rf_write_data, w.d);
            end
        end
    endtask

    initial begin
        logic [31:0] d0;
        n_asrt      = 0;
        n_fail      = 0;
        rst_b       = 1'b0;
        req_valid   = '1;
        req_reg     = '0;
        req_data    = '0;
        claim_valid = 1'b0;
        claim_reg   = '0;
        flush       = 1'b0;

        // reset state
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        tick();
        tick();
        chk("rst_wreq", 32'(rf_write_req), 0);
        chk("rst_waddr", 32'(rf_write), 0);
        chk("rst_wdata", rf_write_data, 0);
        chk("rst_pend", 32'(pending), 0);
        req_valid = '0;
        rst_b     = 1'b1;
        tick();

        // single write
        req_valid      = 3'b001;
        req_reg[3:0]   = 4'd3;
        req_data[31:0] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 32'(req_ready), 32'b001);
        push(4'd3, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        chk("single_wreq", 32'(rf_write_req), 1);

        // fixed priority
        req_valid       = 3'b011;
        req_reg[3:0]    = 4'd1;
        req_data[31:0]  = 32'hA1A1A1A1;
        req_reg[7:4]    = 4'd2;
        req_data[63:32] = 32'hB2B2B2B2;
        #1;
        chk("prio_ready0", 32'(req_ready), 32'b001);
        push(4'd1, 32'hA1A1A1A1);
        tick();
        req_valid = 3'b010;
        #1;
        chk("prio_ready1", 32'(req_ready), 32'b010);
        push(4'd2, 32'hB2B2B2B2);
        tick();
        req_valid = '0;
        tick();
        chk("idle_wreq", 32'(rf_write_req), 0);
        chk("hold_addr", 32'(rf_write), 2);
        chk("hold_data", rf_write_data, 32'hB2B2B2B2);

        // starvation escape
        d0              = 32'h00000100;
        req_valid       = 3'b011;
        req_reg[3:0]    = 4'd4;
        req_reg[7:4]    = 4'd7;
        req_data[63:32] = 32'h77777777;
        for (int k = 1; k <= 4; k++) begin
            req_data[31:0] = d0;
            #1;
            chk("starve_r0", 32'(req_ready), 32'b001);
            push(4'd4, d0);
            tick();
            d0 = d0 + 1;
        end
        req_data[31:0] = d0;
        #1;
        chk("starve_r1", 32'(req_ready), 32'b010);
        push(4'd7, 32'h77777777);
        tick();
        req_valid = 3'b001;
        #1;
        chk("starve_resume", 32'(req_ready), 32'b001);
        push(4'd4, d0);
        tick();
        req_valid = '0;
        tick();

        // scoreboard
        claim_valid = 1'b1;
        claim_reg   = 4'd5;
        tick();
        claim_valid = 1'b0;
        chk("sb_claim", 32'(pending), 32'h0020);
        req_valid      = 3'b001;
        req_reg[3:0]   = 4'd5;
        req_data[31:0] = 32'h55555555;
        #1;
        push(4'd5, 32'h55555555);
        tick();
        req_valid = '0;
        chk("sb_inflight", 32'(pending), 32'h0020);
        tick();
        chk("sb_cleared", 32'(pending), 32'h0000);
        claim_valid = 1'b1;
        tick();
        claim_valid    = 1'b0;
        req_valid      = 3'b001;
        req_data[31:0] = 32'h56565656;
        #1;
        push(4'd5, 32'h56565656);
        tick();
        req_valid   = '0;
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        chk("sb_set_wins", 32'(pending), 32'h0020);

        // register 15 through the LDM source
        req_valid        = 3'b100;
        req_reg[11:8]    = 4'hF;
        req_data[95:64]  = 32'hFFFFFFFF;
        claim_valid      = 1'b1;
        claim_reg        = 4'hF;
        #1;
        chk("r15_ready", 32'(req_ready), 32'b100);
        push(4'hF, 32'hFFFFFFFF);
        tick();
        claim_valid = 1'b0;
        req_valid   = '0;
        chk("r15_pend", 32'(pending), 32'h8020);
        tick();
        chk("r15_clear", 32'(pending), 32'h0020);

        // flush
        claim_valid = 1'b1;
        claim_reg   = 4'd4;
        tick();
        claim_reg = 4'd6;
        tick();
        claim_reg = 4'd7;
        tick();
        claim_valid = 1'b0;
        chk("fl_pend_pre", 32'(pending), 32'h00F0);
        req_valid      = 3'b001;
        req_reg[3:0]   = 4'd8;
        req_data[31:0] = 32'h88888888;
        #1;
        push(4'd8, 32'h88888888);
        tick();
        req_valid       = 3'b010;
        req_reg[7:4]    = 4'd9;
        req_data[63:32] = 32'h99999999;
        flush           = 1'b1;
        claim_valid     = 1'b1;
        claim_reg       = 4'd2;
        #1;
        chk("fl_ready", 32'(req_ready), 0);
        chk("fl_staged", 32'(rf_write_req), 1);
        tick();
        flush       = 1'b0;
        claim_valid = 1'b0;
        chk("fl_pend", 32'(pending), 0);
        chk("fl_wreq", 32'(rf_write_req), 0);
        #1;
        chk("fl_after", 32'(req_ready), 32'b010);
        push(4'd9, 32'h99999999);
        tick();
        req_valid = '0;
        tick();

        // reset during a staged write
        req_valid      = 3'b001;
        req_reg[3:0]   = 4'd10;
        req_data[31:0] = 32'hCCCCCCCC;
        claim_valid    = 1'b1;
        claim_reg      = 4'd10;
        #1;
        push(4'd10, 32'hCCCCCCCC);
        tick();
        chk("mid_pend_pre", 32'(pending), 32'h0400);
        rst_b       = 1'b0;
        req_valid   = '0;
        claim_valid = 1'b0;
        #1;
        chk("mid_wreq", 32'(rf_write_req), 0);
        chk("mid_pend", 32'(pending), 0);
        chk("mid_waddr", 32'(rf_write), 0);
        tick();
        rst_b = 1'b1;
        tick();
        tick();
        chk("mid_nowrite", 32'(rf_write_req), 0);
        chk("exp_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
